// File: rtl/fp_align_add.sv
// fp_align_add: two-stage align/add front end of the single-precision adder.
// Stage 1 classifies the operands, picks the larger magnitude and computes the
// exponent difference; stage 2 shifts the smaller mantissa with sticky
// collection, adds or subtracts, and holds the fields Normalize consumes.
module fp_align_add #(
  parameter int EXP_W   = 8,
  parameter int FRAC_W  = 23,
  parameter int GUARD_W = 8,
  localparam int OP_W   = 1 + EXP_W + FRAC_W,
  localparam int AL_W   = 1 + FRAC_W + GUARD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   A_o,
  output logic [OP_W-1:0]   B_o,
  output logic              signA,
  output logic              signB,
  output logic              ANaN,
  output logic              BNaN,
  output logic              Ainf,
  output logic              Binf,
  output logic              Azero,
  output logic              Bzero,
  output logic              alignedSign,
  output logic [EXP_W-1:0]  exponentOut,
  output logic [AL_W-1:0]   alignedResult,
  output logic              carryOut
);

  // Pipeline occupancy as seen from the two stage valid bits.
  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } occ_t;

  occ_t occ;

  // Stage control.
  logic s1_valid, s2_valid;
  logic s1_valid_next, s2_valid_next;
  logic s1_load, s2_load, s2_take;

  // Stage 1 registered fields.
  logic [OP_W-1:0]  s1_a, s1_b;
  logic             s1_a_nan, s1_b_nan, s1_a_inf, s1_b_inf, s1_a_zero, s1_b_zero;
  logic             s1_sign_l, s1_sign_s;
  logic [EXP_W-1:0] s1_exp_l, s1_shift;
  logic [AL_W-1:0]  s1_man_l, s1_man_s;

  // Stage 1 combinational classification and ordering.
  logic [EXP_W-1:0]  exp_a, exp_b, eff_a, eff_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [AL_W-1:0]   man_a, man_b;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              swap;

  // Stage 2 combinational alignment and add.
  logic [31:0]     shift_amt;
  logic            lost;
  logic [AL_W-1:0] man_s_al;
  logic [AL_W:0]   sum;
  logic [AL_W-1:0] diff;
  logic            res_sign;
  logic [AL_W-1:0] res_man;
  logic            res_carry;

  assign out_valid = s2_valid;

  // Occupancy decode, handshake and next-state of the two stage valid bits.
  always_comb begin
    occ           = EMPTY;
    s2_load       = 1'b0;
    in_ready      = 1'b1;
    s1_load       = 1'b0;
    s2_take       = 1'b0;
    s1_valid_next = s1_valid;
    s2_valid_next = s2_valid;

    if (s1_valid && s2_valid) begin
      occ = FULL;
    end else if (s1_valid || s2_valid) begin
      occ = HALF;
    end

    // A stalled output only blocks new input once both stages hold data.
    s2_load  = !s2_valid || out_ready;
    in_ready = (occ == FULL) ? s2_load : (!s1_valid || s2_load);

    s1_load = in_valid && in_ready;
    s2_take = s2_load && s1_valid;

    if (in_ready) begin
      s1_valid_next = in_valid;
    end
    if (s2_load) begin
      s2_valid_next = s1_valid;
    end
  end

  // Stage valid bits; reset discards anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid_next;
      s2_valid <= s2_valid_next;
    end
  end

  // Classify both operands and order them by magnitude.
  always_comb begin
    exp_a  = A[OP_W-2 -: EXP_W];
    exp_b  = B[OP_W-2 -: EXP_W];
    frac_a = A[FRAC_W-1:0];
    frac_b = B[FRAC_W-1:0];

    a_nan  = (exp_a == '1) && (frac_a != '0);
    b_nan  = (exp_b == '1) && (frac_b != '0);
    a_inf  = (exp_a == '1) && (frac_a == '0);
    b_inf  = (exp_b == '1) && (frac_b == '0);
    a_zero = (exp_a == '0) && (frac_a == '0);
    b_zero = (exp_b == '0) && (frac_b == '0);

    // Subnormals share the exponent of the smallest normal but lack the hidden one.
    eff_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eff_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
    man_a = {(exp_a != '0), frac_a, {GUARD_W{1'b0}}};
    man_b = {(exp_b != '0), frac_b, {GUARD_W{1'b0}}};

    // Ties keep A on the large side so equal magnitudes take A's sign.
    swap = B[OP_W-2:0] > A[OP_W-2:0];
  end

  // Stage 1 register: capture operands, flags and the ordered mantissas.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_nan  <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_a_inf  <= 1'b0;
      s1_b_inf  <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_sign_l <= 1'b0;
      s1_sign_s <= 1'b0;
      s1_exp_l  <= '0;
      s1_shift  <= '0;
      s1_man_l  <= '0;
      s1_man_s  <= '0;
    end else if (s1_load) begin
      s1_a      <= A;
      s1_b      <= B;
      s1_a_nan  <= a_nan;
      s1_b_nan  <= b_nan;
      s1_a_inf  <= a_inf;
      s1_b_inf  <= b_inf;
      s1_a_zero <= a_zero;
      s1_b_zero <= b_zero;
      if (swap) begin
        s1_sign_l <= B[OP_W-1];
        s1_sign_s <= A[OP_W-1];
        s1_exp_l  <= eff_b;
        s1_shift  <= eff_b - eff_a;
        s1_man_l  <= man_b;
        s1_man_s  <= man_a;
      end else begin
        s1_sign_l <= A[OP_W-1];
        s1_sign_s <= B[OP_W-1];
        s1_exp_l  <= eff_a;
        s1_shift  <= eff_a - eff_b;
        s1_man_l  <= man_a;
        s1_man_s  <= man_b;
      end
    end
  end

  // Align the smaller mantissa with sticky collection, then add or subtract.
  always_comb begin
    shift_amt = 32'(s1_shift);
    lost      = 1'b0;
    man_s_al  = '0;

    if (shift_amt >= AL_W) begin
      man_s_al = {{(AL_W-1){1'b0}}, |s1_man_s};
    end else begin
      // Bits that fall off the bottom are exactly those left after shifting up
      // by the complementary amount; a zero shift leaves nothing behind.
      lost     = |(s1_man_s << (AL_W - shift_amt));
      man_s_al = (s1_man_s >> shift_amt) | {{(AL_W-1){1'b0}}, lost};
    end

    sum  = {1'b0, s1_man_l} + {1'b0, man_s_al};
    diff = s1_man_l - man_s_al;

    if (s1_sign_l == s1_sign_s) begin
      res_man   = sum[AL_W-1:0];
      res_carry = sum[AL_W];
      res_sign  = s1_sign_l;
    end else begin
      // The large side never underflows; an exact cancel is reported as +0.
      res_man   = diff;
      res_carry = 1'b0;
      res_sign  = (diff == '0) ? 1'b0 : s1_sign_l;
    end
  end

  // Stage 2 register: result fields, held while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      A_o           <= '0;
      B_o           <= '0;
      signA         <= 1'b0;
      signB         <= 1'b0;
      ANaN          <= 1'b0;
      BNaN          <= 1'b0;
      Ainf          <= 1'b0;
      Binf          <= 1'b0;
      Azero         <= 1'b0;
      Bzero         <= 1'b0;
      alignedSign   <= 1'b0;
      exponentOut   <= '0;
      alignedResult <= '0;
      carryOut      <= 1'b0;
    end else if (s2_take) begin
      A_o           <= s1_a;
      B_o           <= s1_b;
      signA         <= s1_a[OP_W-1];
      signB         <= s1_b[OP_W-1];
      ANaN          <= s1_a_nan;
      BNaN          <= s1_b_nan;
      Ainf          <= s1_a_inf;
      Binf          <= s1_b_inf;
      Azero         <= s1_a_zero;
      Bzero         <= s1_b_zero;
      alignedSign   <= res_sign;
      exponentOut   <= s1_exp_l;
      alignedResult <= res_man;
      carryOut      <= res_carry;
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add: directed and random operand pairs through fp_align_add,
// checked against a reference model via an in-order scoreboard.
module tb_fp_align_add;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A_o, B_o;
  logic        signA, signB, ANaN, BNaN, Ainf, Binf, Azero, Bzero;
  logic        alignedSign;
  logic [7:0]  exponentOut;
  logic [31:0] alignedResult;
  logic        carryOut;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a, b;
    logic [31:0] res;
    logic        carry, sign;
    logic [7:0]  expo;
    logic [5:0]  flags;
    logic        has_ref;
    logic [31:0] ref_res;
    logic        ref_carry, ref_sign;
  } exp_t;

  exp_t sb[$];

  fp_align_add dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .A_o(A_o), .B_o(B_o), .signA(signA), .signB(signB),
    .ANaN(ANaN), .BNaN(BNaN), .Ainf(Ainf), .Binf(Binf),
    .Azero(Azero), .Bzero(Bzero),
    .alignedSign(alignedSign), .exponentOut(exponentOut),
    .alignedResult(alignedResult), .carryOut(carryOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: bit-serial sticky shift, wide add.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] l, s, ml, ms;
    logic [7:0]  el, es, effl, effs;
    logic [32:0] sum;
    logic        sticky;
    int          d;
    e = '{default: '0};
    e.a = a;
    e.b = b;
    if (b[30:0] > a[30:0]) begin l = b; s = a; end
    else begin l = a; s = b; end
    el   = l[30:23];
    es   = s[30:23];
    effl = (el == 8'd0) ? 8'd1 : el;
    effs = (es == 8'd0) ? 8'd1 : es;
    d    = int'(effl) - int'(effs);
    ml   = {(el != 8'd0), l[22:0], 8'h00};
    ms   = {(es != 8'd0), s[22:0], 8'h00};
    sticky = 1'b0;
    for (int i = 0; i < d; i++) begin
      sticky = sticky | ms[0];
      ms     = ms >> 1;
    end
    ms[0] = ms[0] | sticky;
    if (l[31] == s[31]) begin
      sum     = {1'b0, ml} + {1'b0, ms};
      e.res   = sum[31:0];
      e.carry = sum[32];
      e.sign  = l[31];
    end else begin
      e.res   = ml - ms;
      e.carry = 1'b0;
      e.sign  = (e.res == 32'd0) ? 1'b0 : l[31];
    end
    e.expo  = effl;
    e.flags = {(a[30:23] == 8'hFF) && (a[22:0] != 0), (b[30:23] == 8'hFF) && (b[22:0] != 0),
               (a[30:23] == 8'hFF) && (a[22:0] == 0), (b[30:23] == 8'hFF) && (b[22:0] == 0),
               (a[30:23] == 8'h00) && (a[22:0] == 0), (b[30:23] == 8'h00) && (b[22:0] == 0)};
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one pair (called at posedge+1); push its expectation once accepted.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic has_ref, input logic [31:0] ref_res,
                                input logic ref_carry, input logic ref_sign);
    exp_t e;
    bit   done;
    e = model(a, b);
    e.has_ref   = has_ref;
    e.ref_res   = ref_res;
    e.ref_carry = ref_carry;
    e.ref_sign  = ref_sign;
    A = a;
    B = b;
    in_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check_output("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      @(posedge clock);
      #1;
    end
    check_output("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: pop and compare every transfer to Normalize.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_output", A_o, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_output("A_o", A_o, e.a);
        check_output("B_o", B_o, e.b);
        check_output("alignedResult", alignedResult, e.res);
        check_output("carryOut", 32'(carryOut), 32'(e.carry));
        check_output("alignedSign", 32'(alignedSign), 32'(e.sign));
        check_output("exponentOut", 32'(exponentOut), 32'(e.expo));
        check_output("flags", 32'({ANaN, BNaN, Ainf, Binf, Azero, Bzero}), 32'(e.flags));
        check_output("signs", 32'({signA, signB}), 32'({e.a[31], e.b[31]}));
        if (e.has_ref) begin
          check_output("ref_result", alignedResult, e.ref_res);
          check_output("ref_carry", 32'(carryOut), 32'(e.ref_carry));
          check_output("ref_sign", 32'(alignedSign), 32'(e.ref_sign));
        end
      end
    end
  end

  logic [31:0] held_res, held_a;

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  re;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state on the cycle after reset.
    @(negedge clock);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_result", alignedResult, 32'd0);
    check_output("rst_exponent", 32'(exponentOut), 32'd0);
    check_output("rst_carry", 32'(carryOut), 32'd0);
    @(posedge clock);
    #1 out_ready = 1'b1;

    // 1.0 + 1.0 alone, with latency check.
    apply_stimulus(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    @(negedge clock);
    check_output("latency_early", 32'(out_valid), 32'd0);
    @(negedge clock);
    check_output("latency_valid", 32'(out_valid), 32'd1);
    check_output("t1_exponent", 32'(exponentOut), 32'h7F);
    @(posedge clock);
    #1;

    // Directed vectors back to back.
    apply_stimulus(32'h3FC00000, 32'hBF800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
    apply_stimulus(32'h3F800000, 32'h30800000, 1'b1, 32'h80000002, 1'b0, 1'b0);
    apply_stimulus(32'h3F800000, 32'h2B800000, 1'b1, 32'h80000001, 1'b0, 1'b0);
    apply_stimulus(32'h3F800000, 32'hBF800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    apply_stimulus(32'hBF800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    apply_stimulus(32'h7FC00000, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(32'h7F800000, 32'hFF800000, 1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(32'h00000000, 32'h80000000, 1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(32'h00400000, 32'h00200001, 1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(32'h3F800001, 32'hBF800000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Random pairs, mostly with nearby exponents.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 != 3) begin
        re = ra[30:23] + 8'($urandom_range(0, 40)) - 8'd20;
        rb[30:23] = re;
      end
      apply_stimulus(ra, rb, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    drain();

    // Stall: four pairs while Normalize holds off for several cycles.
    out_ready = 1'b0;
    fork
      begin
        apply_stimulus(32'h40000000, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b0);
        apply_stimulus(32'h40400000, 32'hC0000000, 1'b0, 32'h0, 1'b0, 1'b0);
        apply_stimulus(32'h41200000, 32'h3DCCCCCD, 1'b0, 32'h0, 1'b0, 1'b0);
        apply_stimulus(32'hC2C80000, 32'hC2C80000, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("full_in_ready", 32'(in_ready), 32'd0);
        check_output("full_out_valid", 32'(out_valid), 32'd1);
        held_res = alignedResult;
        held_a   = A_o;
        @(negedge clock);
        check_output("hold_in_ready", 32'(in_ready), 32'd0);
        check_output("hold_result", alignedResult, held_res);
        check_output("hold_A_o", A_o, held_a);
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two pairs in flight.
    apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(32'h40800000, 32'h3F000000, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    drain();
    @(negedge clock);
    check_output("idle_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
